// File: rtl/br_sched_pkg.sv
// Shared types and constants for the branch tag scheduler.
// Branch capacity is fixed here; a tag is the index of its slot in the age queue.
package br_sched_pkg;

    localparam int NUM_BR_TAGS = 4;
    localparam int BR_TAG_LEN  = $clog2(NUM_BR_TAGS);

    typedef logic [BR_TAG_LEN-1:0]  br_tag_t;
    typedef logic [NUM_BR_TAGS-1:0] br_mask_t;
    typedef logic [BR_TAG_LEN:0]    br_cnt_t;

    // Distance from the oldest slot; the queue size is a power of two, so wrap is free.
    function automatic br_tag_t br_age(input br_tag_t tag, input br_tag_t head);
        return tag - head;
    endfunction

endpackage

// File: rtl/br_age_arbiter.sv
// Oldest-first picker over resolution ports; ties go to the lowest port index.
// Latency: combinational.
// Backpressure: eligible losers get ready=0 and hold; valid but ineligible ports are drained.
module br_age_arbiter
    import br_sched_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [NUM_PORTS-1:0]            req_eligible,
    input  logic [NUM_PORTS*BR_TAG_LEN-1:0] req_tag,
    input  logic [BR_TAG_LEN-1:0]           head,
    output logic [NUM_PORTS-1:0]            win_onehot,
    output logic                            win_valid,
    output logic [NUM_PORTS-1:0]            ready
);

    br_tag_t best_age;
    br_tag_t port_age;

    always_comb begin
        win_onehot = '0;
        win_valid  = 1'b0;
        best_age   = '0;
        port_age   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_age = br_age(req_tag[p*BR_TAG_LEN +: BR_TAG_LEN], head);
            // Strict less-than keeps the lower index on an age tie.
            if (req_eligible[p] && (!win_valid || (port_age < best_age))) begin
                win_onehot    = '0;
                win_onehot[p] = 1'b1;
                win_valid     = 1'b1;
                best_age      = port_age;
            end
        end
        ready = (req_valid & ~req_eligible) | win_onehot;
    end

endmodule

// File: rtl/branch_tag_scheduler.sv
// Branch tag allocator/resolver; optional BR_SCHED_STATS_EN adds saturating pulse counters.
// Latency: alloc grant combinational; resolve/kill pulses one cycle after the winning report.
// Backpressure: alloc refused when full or during a kill; losing resolution ports hold via res_ready=0.
module branch_tag_scheduler
    import br_sched_pkg::*;
#(
    parameter int NUM_RES_PORTS = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              alloc_req,
    output logic                              alloc_gnt,
    output logic [BR_TAG_LEN-1:0]             alloc_tag,
    output logic [NUM_BR_TAGS-1:0]            alloc_mask,
    input  logic [NUM_RES_PORTS-1:0]          res_valid,
    input  logic [NUM_RES_PORTS*BR_TAG_LEN-1:0] res_tag,
    input  logic [NUM_RES_PORTS-1:0]          res_mispredict,
    output logic [NUM_RES_PORTS-1:0]          res_ready,
    output logic                              resolve,
    output logic [BR_TAG_LEN-1:0]             resolve_tag,
    output logic                              kill,
    output logic [BR_TAG_LEN-1:0]             kill_tag,
    output logic [NUM_BR_TAGS-1:0]            kill_mask,
    output logic                              full,
    output logic                              busy
`ifdef BR_SCHED_STATS_EN
    ,
    output logic [31:0]                       stat_resolved,
    output logic [31:0]                       stat_killed
`endif
);

    br_mask_t valid_q, resolved_q, valid_d, resolved_d;
    br_tag_t  head_q, tail_q;
    br_cnt_t  count_q;

    logic [NUM_RES_PORTS-1:0] res_eligible;
    logic [NUM_RES_PORTS-1:0] win_onehot;
    logic                     win_valid;
    br_tag_t                  win_tag;
    br_tag_t                  win_age;
    logic                     win_mispredict;
    logic                     mispredict_accepted;
    logic                     correct_accepted;
    logic                     retire;
    br_mask_t                 squash_mask;

    always_comb begin
        res_eligible = '0;
        for (int p = 0; p < NUM_RES_PORTS; p++) begin
            res_eligible[p] = res_valid[p]
                            & valid_q[res_tag[p*BR_TAG_LEN +: BR_TAG_LEN]]
                            & ~resolved_q[res_tag[p*BR_TAG_LEN +: BR_TAG_LEN]];
        end
    end

    br_age_arbiter #(.NUM_PORTS(NUM_RES_PORTS)) u_arb (
        .req_valid    (res_valid),
        .req_eligible (res_eligible),
        .req_tag      (res_tag),
        .head         (head_q),
        .win_onehot   (win_onehot),
        .win_valid    (win_valid),
        .ready        (res_ready)
    );

    always_comb begin
        win_tag        = '0;
        win_mispredict = 1'b0;
        for (int p = 0; p < NUM_RES_PORTS; p++) begin
            if (win_onehot[p]) begin
                win_tag        = win_tag | res_tag[p*BR_TAG_LEN +: BR_TAG_LEN];
                win_mispredict = win_mispredict | res_mispredict[p];
            end
        end
    end

    assign mispredict_accepted = win_valid & win_mispredict;
    assign correct_accepted    = win_valid & ~win_mispredict;
    assign win_age             = br_age(win_tag, head_q);

    // Killed slot and everything younger: age at or beyond the killed tag's age.
    always_comb begin
        squash_mask = '0;
        for (int i = 0; i < NUM_BR_TAGS; i++) begin
            squash_mask[i] = valid_q[i] & (br_age(BR_TAG_LEN'(i), head_q) >= win_age);
        end
    end

    assign full       = (count_q == br_cnt_t'(NUM_BR_TAGS));
    assign busy       = (count_q != '0);
    assign retire     = valid_q[head_q] & resolved_q[head_q];
    assign alloc_gnt  = alloc_req & ~full & ~kill & ~mispredict_accepted;
    assign alloc_tag  = tail_q;
    assign alloc_mask = valid_q;

    always_comb begin
        valid_d    = valid_q;
        resolved_d = resolved_q;
        if (retire) begin
            valid_d[head_q]    = 1'b0;
            resolved_d[head_q] = 1'b0;
        end
        if (correct_accepted) begin
            resolved_d[win_tag] = 1'b1;
        end
        if (mispredict_accepted) begin
            valid_d    = valid_d & ~squash_mask;
            resolved_d = resolved_d & ~squash_mask;
        end
        if (alloc_gnt) begin
            valid_d[tail_q]    = 1'b1;
            resolved_d[tail_q] = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q     <= '0;
            resolved_q  <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            resolve     <= 1'b0;
            resolve_tag <= '0;
            kill        <= 1'b0;
            kill_tag    <= '0;
            kill_mask   <= '0;
        end else begin
            valid_q    <= valid_d;
            resolved_q <= resolved_d;
            if (retire) begin
                head_q <= head_q + br_tag_t'(1);
            end
            if (mispredict_accepted) begin
                tail_q  <= win_tag;
                count_q <= br_cnt_t'(win_age) - br_cnt_t'(retire);
            end else begin
                if (alloc_gnt) begin
                    tail_q <= tail_q + br_tag_t'(1);
                end
                count_q <= count_q + br_cnt_t'(alloc_gnt) - br_cnt_t'(retire);
            end
            resolve <= correct_accepted;
            kill    <= mispredict_accepted;
            if (correct_accepted) begin
                resolve_tag <= win_tag;
            end
            if (mispredict_accepted) begin
                kill_tag  <= win_tag;
                kill_mask <= squash_mask;
            end
        end
    end

`ifdef BR_SCHED_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_resolved <= '0;
            stat_killed   <= '0;
        end else begin
            if (resolve && (stat_resolved != 32'hFFFF_FFFF)) begin
                stat_resolved <= stat_resolved + 32'd1;
            end
            if (kill && (stat_killed != 32'hFFFF_FFFF)) begin
                stat_killed <= stat_killed + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_tag_scheduler.sv
// Directed table-driven bench for branch_tag_scheduler (4 tags, 2 resolution ports).
module tb_branch_tag_scheduler;

    logic       clock;
    logic       reset;
    logic       alloc_req;
    logic       alloc_gnt;
    logic [1:0] alloc_tag;
    logic [3:0] alloc_mask;
    logic [1:0] res_valid;
    logic [3:0] res_tag;
    logic [1:0] res_mispredict;
    logic [1:0] res_ready;
    logic       resolve;
    logic [1:0] resolve_tag;
    logic       kill;
    logic [1:0] kill_tag;
    logic [3:0] kill_mask;
    logic       full;
    logic       busy;
`ifdef BR_SCHED_STATS_EN
    logic [31:0] stat_resolved;
    logic [31:0] stat_killed;
`endif

    branch_tag_scheduler #(.NUM_RES_PORTS(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .alloc_req      (alloc_req),
        .alloc_gnt      (alloc_gnt),
        .alloc_tag      (alloc_tag),
        .alloc_mask     (alloc_mask),
        .res_valid      (res_valid),
        .res_tag        (res_tag),
        .res_mispredict (res_mispredict),
        .res_ready      (res_ready),
        .resolve        (resolve),
        .resolve_tag    (resolve_tag),
        .kill           (kill),
        .kill_tag       (kill_tag),
        .kill_mask      (kill_mask),
        .full           (full),
        .busy           (busy)
`ifdef BR_SCHED_STATS_EN
        ,
        .stat_resolved  (stat_resolved),
        .stat_killed    (stat_killed)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic       rst;
        logic       areq;
        logic [1:0] rv;
        logic [3:0] rt;
        logic [1:0] rm;
        logic       gnt;
        logic [1:0] atag;
        logic [3:0] amask;
        logic [1:0] rdy;
        logic       res;
        logic [1:0] rtag;
        logic       kil;
        logic [1:0] ktag;
        logic [3:0] kmask;
        logic       full;
        logic       busy;
    } row_t;

    row_t rows[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic rst, input logic areq, input logic [1:0] rv,
                       input logic [1:0] t1, input logic [1:0] t0, input logic [1:0] rm,
                       input logic gnt, input logic [1:0] atag, input logic [3:0] amask,
                       input logic [1:0] rdy, input logic res, input logic [1:0] rtag,
                       input logic kil, input logic [1:0] ktag, input logic [3:0] kmask,
                       input logic f, input logic b);
        row_t r;
        r.rst = rst; r.areq = areq; r.rv = rv; r.rt = {t1, t0}; r.rm = rm;
        r.gnt = gnt; r.atag = atag; r.amask = amask; r.rdy = rdy;
        r.res = res; r.rtag = rtag; r.kil = kil; r.ktag = ktag; r.kmask = kmask;
        r.full = f; r.busy = b;
        rows.push_back(r);
    endtask

    task automatic add_reset();
        add(1, 0, 2'b00, 0, 0, 2'b00, 0, 0, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b0000, 0, 0);
    endtask

    // From empty: allocate tags 0..3.
    task automatic add_fill4();
        add(0, 1, 2'b00, 0, 0, 2'b00, 1, 0, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b0000, 0, 0);
        add(0, 1, 2'b00, 0, 0, 2'b00, 1, 1, 4'b0001, 2'b00, 0, 0, 0, 0, 4'b0000, 0, 1);
        add(0, 1, 2'b00, 0, 0, 2'b00, 1, 2, 4'b0011, 2'b00, 0, 0, 0, 0, 4'b0000, 0, 1);
        add(0, 1, 2'b00, 0, 0, 2'b00, 1, 3, 4'b0111, 2'b00, 0, 0, 0, 0, 4'b0000, 0, 1);
    endtask

    task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    initial begin
        reset          = 1'b1;
        alloc_req      = 1'b0;
        res_valid      = '0;
        res_tag        = '0;
        res_mispredict = '0;

        // Allocation ramp to full, then full queue refuses even while head retires.
        add_fill4();
        add(0, 1, 2'b00, 0, 0, 2'b00, 0, 0, 4'b1111, 2'b00, 0, 0, 0, 0, 4'b0000, 1, 1);
        // Oldest-first: port1 tag0 beats port0 tag2.
        add(0, 0, 2'b11, 0, 2, 2'b00, 0, 0, 4'b1111, 2'b10, 0, 0, 0, 0, 4'b0000, 1, 1);
        add(0, 1, 2'b01, 0, 2, 2'b00, 0, 0, 4'b1111, 2'b01, 1, 0, 0, 0, 4'b0000, 1, 1);
        add(0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 4'b1110, 2'b00, 1, 2, 0, 0, 4'b0000, 0, 1);
        add_reset();
        // Mispredict tag1 squashes 1..3; allocation blocked during kill, then tag1 reused.
        add_fill4();
        add(0, 1, 2'b01, 0, 1, 2'b01, 0, 0, 4'b1111, 2'b01, 0, 0, 0, 0, 4'b0000, 1, 1);
        add(0, 1, 2'b00, 0, 0, 2'b00, 0, 0, 4'b0001, 2'b00, 0, 0, 1, 1, 4'b1110, 0, 1);
        add(0, 1, 2'b00, 0, 0, 2'b00, 1, 1, 4'b0001, 2'b00, 0, 0, 0, 0, 4'b0000, 0, 1);
        add(0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 4'b0011, 2'b00, 0, 0, 0, 0, 4'b0000, 0, 1);
        add_reset();
        // Older correct report outranks younger mispredict.
        add_fill4();
        add(0, 0, 2'b11, 1, 3, 2'b01, 0, 0, 4'b1111, 2'b10, 0, 0, 0, 0, 4'b0000, 1, 1);
        add(0, 0, 2'b01, 0, 3, 2'b01, 0, 0, 4'b1111, 2'b01, 1, 1, 0, 0, 4'b0000, 1, 1);
        add(0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 4'b0111, 2'b00, 0, 0, 1, 3, 4'b1000, 0, 1);
        add_reset();
        // Wrap: retire 0..2, hold tags 3,0, kill tag0, stale report for tag0 is dropped.
        add(0, 1, 2'b00, 0, 0, 2'b00, 1, 0, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b0000, 0, 0);
        add(0, 1, 2'b00, 0, 0, 2'b00, 1, 1, 4'b0001, 2'b00, 0, 0, 0, 0, 4'b0000, 0, 1);
        add(0, 1, 2'b00, 0, 0, 2'b00, 1, 2, 4'b0011, 2'b00, 0, 0, 0, 0, 4'b0000, 0, 1);
        add(0, 0, 2'b11, 1, 0, 2'b00, 0, 0, 4'b0111, 2'b01, 0, 0, 0, 0, 4'b0000, 0, 1);
        add(0, 0, 2'b11, 1, 2, 2'b00, 0, 0, 4'b0111, 2'b10, 1, 0, 0, 0, 4'b0000, 0, 1);
        add(0, 0, 2'b01, 0, 2, 2'b00, 0, 0, 4'b0110, 2'b01, 1, 1, 0, 0, 4'b0000, 0, 1);
        add(0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 4'b0100, 2'b00, 1, 2, 0, 0, 4'b0000, 0, 1);
        add(0, 1, 2'b00, 0, 0, 2'b00, 1, 3, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b0000, 0, 0);
        add(0, 1, 2'b00, 0, 0, 2'b00, 1, 0, 4'b1000, 2'b00, 0, 0, 0, 0, 4'b0000, 0, 1);
        add(0, 0, 2'b01, 0, 0, 2'b01, 0, 0, 4'b1001, 2'b01, 0, 0, 0, 0, 4'b0000, 0, 1);
        add(0, 0, 2'b01, 0, 0, 2'b00, 0, 0, 4'b1000, 2'b01, 0, 0, 1, 0, 4'b0001, 0, 1);
        add(0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 4'b1000, 2'b00, 0, 0, 0, 0, 4'b0000, 0, 1);

        // Reset state.
        @(negedge clock);
        chk("reset_busy",   -1, 8'(busy), 8'h0);
        chk("reset_full",   -1, 8'(full), 8'h0);
        chk("reset_kill",   -1, 8'(kill), 8'h0);
        chk("reset_resolve",-1, 8'(resolve), 8'h0);
        chk("reset_amask",  -1, 8'(alloc_mask), 8'h0);
        @(posedge clock); #1;

        for (int i = 0; i < rows.size(); i++) begin
            reset          = rows[i].rst;
            alloc_req      = rows[i].areq;
            res_valid      = rows[i].rv;
            res_tag        = rows[i].rt;
            res_mispredict = rows[i].rm;
            @(negedge clock);
            chk("alloc_gnt",  i, 8'(alloc_gnt),  8'(rows[i].gnt));
            if (rows[i].gnt) chk("alloc_tag", i, 8'(alloc_tag), 8'(rows[i].atag));
            chk("alloc_mask", i, 8'(alloc_mask), 8'(rows[i].amask));
            chk("res_ready",  i, 8'(res_ready),  8'(rows[i].rdy));
            chk("resolve",    i, 8'(resolve),    8'(rows[i].res));
            if (rows[i].res) chk("resolve_tag", i, 8'(resolve_tag), 8'(rows[i].rtag));
            chk("kill",       i, 8'(kill),       8'(rows[i].kil));
            if (rows[i].kil) begin
                chk("kill_tag",  i, 8'(kill_tag),  8'(rows[i].ktag));
                chk("kill_mask", i, 8'(kill_mask), 8'(rows[i].kmask));
            end
            chk("full",       i, 8'(full),       8'(rows[i].full));
            chk("busy",       i, 8'(busy),       8'(rows[i].busy));
            @(posedge clock); #1;
        end

        // Reset lands before the edge that would register a kill of tag3.
        reset          = 1'b0;
        alloc_req      = 1'b0;
        res_valid      = 2'b01;
        res_tag        = 4'b0011;
        res_mispredict = 2'b01;
        @(negedge clock);
        chk("pend_ready", 100, 8'(res_ready), 8'h1);
        reset     = 1'b1;
        res_valid = 2'b00;
        @(posedge clock); #1;
        chk("pend_kill",  100, 8'(kill), 8'h0);
        chk("pend_busy",  100, 8'(busy), 8'h0);
        chk("pend_full",  100, 8'(full), 8'h0);
        chk("pend_amask", 100, 8'(alloc_mask), 8'h0);
`ifdef BR_SCHED_STATS_EN
        chk("stat_resolved", 100, stat_resolved[7:0], 8'h0);
        chk("stat_killed",   100, stat_killed[7:0],   8'h0);
`endif
        reset = 1'b0;
        @(posedge clock); #1;
        chk("post_kill", 101, 8'(kill), 8'h0);
        alloc_req = 1'b1;
        @(negedge clock);
        chk("post_gnt", 101, 8'(alloc_gnt), 8'h1);
        chk("post_tag", 101, 8'(alloc_tag), 8'h0);
        @(posedge clock); #1;
        alloc_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
